// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler that shares one W-bit PISO between NUM_REQ word producers.
// Each frame is granted in IDLE, loaded in LOAD, qualified over W SHIFT cycles and followed by GAP_CYCLES idle cycles.
module piso_tx_scheduler #(
  parameter int W          = 8,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*W-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   piso_load,
  output logic [W-1:0]           piso_data,
  output logic                   bit_valid,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id,
  output logic                   frame_done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
  localparam logic [3:0] GAP_INIT = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [IDW-1:0]  rr_ptr_reg;
  logic [IDW-1:0]  grant_id_reg;
  logic [CW-1:0]   bit_cnt_reg;
  logic [3:0]      gap_cnt_reg;
  logic [W-1:0]    data_reg;

  logic [W-1:0]       req_word [NUM_REQ];
  logic [IDW-1:0]     cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_vld;
  logic               pick_valid;
  logic [IDW-1:0]     pick_idx;

  // Candidate gi is the requester (rr_ptr + 1 + gi) mod NUM_REQ, so the
  // search order always starts just after the last served requester.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [IDW:0] sum;

      assign req_word[gi] = req_data[gi*W +: W];
      assign sum          = {1'b0, rr_ptr_reg} + (IDW+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (IDW+1)'(NUM_REQ)) ?
                            IDW'(sum - (IDW+1)'(NUM_REQ)) : sum[IDW-1:0];
      assign cand_vld[gi] = req_valid[cand_idx[gi]];
    end
  endgenerate

  // Lowest candidate position wins, i.e. the first valid one in rotated order.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_vld[k]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (enable && pick_valid) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = SHIFT;
      end
      SHIFT: begin
        if (bit_cnt_reg == '0) begin
          state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_reg == '0) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg   <= IDW'(NUM_REQ - 1);
      grant_id_reg <= '0;
      bit_cnt_reg  <= '0;
      gap_cnt_reg  <= '0;
      data_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable && pick_valid) begin
            grant_id_reg <= pick_idx;
          end
        end
        LOAD: begin
          rr_ptr_reg  <= grant_id_reg;
          bit_cnt_reg <= LAST_BIT;
          data_reg    <= req_word[grant_id_reg];
        end
        SHIFT: begin
          if (bit_cnt_reg != '0) begin
            bit_cnt_reg <= bit_cnt_reg - 1'b1;
          end else begin
            gap_cnt_reg <= GAP_INIT;
          end
        end
        GAP: begin
          if (gap_cnt_reg != '0) begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
          end
        end
        default: begin
          bit_cnt_reg <= '0;
        end
      endcase
    end
  end

  // All strobes decode from registered state; piso_data passes the granted
  // word straight through during LOAD so the PISO captures it on that edge.
  always_comb begin
    req_ready  = '0;
    piso_load  = 1'b0;
    piso_data  = data_reg;
    bit_valid  = 1'b0;
    busy       = (state_reg != IDLE);
    grant_id   = grant_id_reg;
    frame_done = 1'b0;
    case (state_reg)
      LOAD: begin
        req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_reg;
        piso_load = 1'b1;
        piso_data = req_word[grant_id_reg];
      end
      SHIFT: begin
        bit_valid  = 1'b1;
        frame_done = (bit_cnt_reg == '0);
      end
      default: begin
        req_ready = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Scoreboard bench for piso_tx_scheduler: stimulus pushes expected grants, a negedge monitor
// checks each load, the reconstructed serial frame, timing, and a GAP_CYCLES=0 instance.
`timescale 1ns/1ps
module tb_piso_tx_scheduler;
  localparam int W = 8;
  localparam int N = 4;
  localparam int IDW = 2;
  localparam int ABORTED = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n, enable;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           piso_load, bit_valid, busy, frame_done;
  logic [W-1:0]   piso_data;
  logic [IDW-1:0] grant_id;

  logic           g0_rst_n;
  logic [N-1:0]   g0_req_valid;
  logic [N*W-1:0] g0_req_data;
  logic [N-1:0]   g0_req_ready;
  logic           g0_piso_load, g0_bit_valid, g0_busy, g0_frame_done;
  logic [W-1:0]   g0_piso_data;
  logic [IDW-1:0] g0_grant_id;

  piso_tx_scheduler #(.W(W), .NUM_REQ(N), .GAP_CYCLES(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .piso_load(piso_load), .piso_data(piso_data), .bit_valid(bit_valid),
    .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
  );

  piso_tx_scheduler #(.W(W), .NUM_REQ(N), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .reset_n(g0_rst_n), .enable(1'b1),
    .req_valid(g0_req_valid), .req_data(g0_req_data), .req_ready(g0_req_ready),
    .piso_load(g0_piso_load), .piso_data(g0_piso_data), .bit_valid(g0_bit_valid),
    .busy(g0_busy), .grant_id(g0_grant_id), .frame_done(g0_frame_done)
  );

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] word;
    logic [7:0] interval;   // expected cycles since previous load, 0 = unchecked
    logic       resume;     // load must follow the enable rise by one cycle
  } exp_t;

  exp_t exp_tab [32];
  int   exp_wr = 0;
  int   exp_rd = 0;

  logic [W-1:0] word_mem [N][8];
  int   word_rd [N];
  int   word_wr [N];
  logic [N-1:0] rdy_s;
  logic load_s, busy_s;
  int   tmo = 0;
  bit   tb_done = 1'b0;
  bit   mon_final = 1'b0;

  int tests = 0;
  int fails = 0;

  // ---------------- stimulus ----------------
  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (word_rd[i] != word_wr[i]);
      req_data[i*W +: W] = word_mem[i][word_rd[i] % 8];
    end
  endtask

  task automatic push_word(input int i, input logic [7:0] w);
    word_mem[i][word_wr[i] % 8] = w;
    word_wr[i]++;
    drive_reqs();
  endtask

  task automatic push_exp(input int id, input logic [7:0] w, input int iv, input bit rs);
    exp_tab[exp_wr] = '{id: 4'(id), word: w, interval: 8'(iv), resume: rs};
    exp_wr++;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) word_rd[i] = word_wr[i];
    drive_reqs();
  endtask

  // One clock: sample at negedge, retire accepted words just after the edge.
  task automatic step();
    @(negedge clk);
    rdy_s  = req_ready;
    load_s = piso_load;
    busy_s = busy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (rdy_s[i] && word_rd[i] != word_wr[i]) word_rd[i]++;
    drive_reqs();
  endtask

  task automatic wait_load(input int max);
    int n = 0;
    do begin step(); n++; end while (!load_s && n < max);
    if (!load_s) tmo++;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (exp_rd != exp_wr && n < max) begin step(); n++; end
    do begin step(); n++; end while (busy_s && n < max);
    if (n >= max) tmo++;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin word_rd[i] = 0; word_wr[i] = 0; end
    reset_n = 1'b0; enable = 1'b0; g0_rst_n = 1'b0;
    req_valid = '0; req_data = '0;
    g0_req_valid = '0; g0_req_data = {8'h00, 8'h00, 8'hC3, 8'h3C};
    drive_reqs();
    repeat (3) step();
    reset_n = 1'b1; g0_rst_n = 1'b1; g0_req_valid = 4'b0011;
    repeat (2) step();

    // single word on requester 0
    enable = 1'b1;
    push_exp(0, 8'hA5, 0, 0);
    push_word(0, 8'hA5);
    wait_done(60);

    // reset during the 4th shift cycle of 0xC3 (rr_ptr=0, so requester 1 wins)
    push_exp(1, 8'hC3, 0, 0);
    push_word(1, 8'hC3);
    wait_load(20);
    repeat (3) step();
    reset_n = 1'b0;
    clear_reqs();
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // round robin from reset pointer: 0,1,2,3,0 every 11 cycles
    push_exp(0, 8'h11, 0, 0);
    push_exp(1, 8'h22, 11, 0);
    push_exp(2, 8'h33, 11, 0);
    push_exp(3, 8'h44, 11, 0);
    push_exp(0, 8'h11, 11, 0);
    push_word(0, 8'h11); push_word(0, 8'h11);
    push_word(1, 8'h22); push_word(2, 8'h33); push_word(3, 8'h44);
    wait_done(120);

    // wrap fairness: serve 2, then 1 and 3 request -> 3 before 1
    push_exp(2, 8'h5A, 0, 0);
    push_word(2, 8'h5A);
    wait_load(20);
    push_exp(3, 8'h77, 11, 0);
    push_exp(1, 8'h66, 11, 0);
    push_word(1, 8'h66); push_word(3, 8'h77);
    wait_done(80);

    // enable dropped during shift of 0x0F; requester 1 waits until enable returns
    push_exp(0, 8'h0F, 0, 0);
    push_exp(1, 8'h99, 0, 1);
    push_word(0, 8'h0F); push_word(1, 8'h99);
    wait_load(20);
    step();
    enable = 1'b0;
    repeat (20) step();
    enable = 1'b1;
    wait_done(60);

    repeat (3) step();
    tb_done = 1'b1;
    for (int n = 0; n < 10 && !mon_final; n++) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  initial begin
    int cyc = 0, last_load = -1, en_rise = -1, nbits = 0, after_done = 0, frames_seen = 0;
    int g0_last = -1;
    bit en_prev = 1'b0, in_frame = 1'b0;
    logic g0_id = 1'b0;
    logic [7:0] model_sr = '0, assembled = '0, cur_word = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (enable && !en_prev) en_rise = cyc;
      en_prev = enable;

      if (g0_rst_n) begin
        chk("g0_load_vs_bit", {31'd0, g0_bit_valid & g0_piso_load}, 32'd0);
        if (g0_piso_load) begin
          if (g0_last >= 0) chk("g0_period", cyc - g0_last, 10);
          chk("g0_grant", {30'd0, g0_grant_id}, {31'd0, g0_id});
          chk("g0_data", {24'd0, g0_piso_data}, g0_id ? 32'hC3 : 32'h3C);
          g0_id = ~g0_id;
          g0_last = cyc;
        end
      end

      if (!reset_n) begin
        chk("reset_outputs",
            {14'd0, req_ready, piso_load, piso_data, bit_valid, busy, grant_id, frame_done}, 32'd0);
        in_frame = 1'b0; nbits = 0; after_done = 0; last_load = -1;
      end else begin
        if (after_done == 2) begin
          chk("idle_after_gap", {30'd0, busy, bit_valid}, 32'd0);
          after_done = 0;
        end
        if (after_done == 1) begin
          chk("gap_cycle", {30'd0, busy, bit_valid}, 32'd2);
          after_done = 2;
        end
        chk("load_vs_bit", {31'd0, bit_valid & piso_load}, 32'd0);
        if (bit_valid) begin
          assembled = {assembled[6:0], model_sr[7]};
          model_sr  = {model_sr[6:0], 1'b0};
          nbits++;
          if (frame_done) begin
            chk("frame_len", nbits, 8);
            chk("frame_bits", {24'd0, assembled}, {24'd0, cur_word});
            $display("[TB] frame t=%0d word=%02h serial=%02h bits=%0d", cyc, cur_word, assembled, nbits);
            if (in_frame) frames_seen++;
            in_frame = 1'b0;
            after_done = 1;
          end
        end
        if (piso_load) begin
          if (exp_rd == exp_wr) begin
            chk("unexpected_load", {30'd0, grant_id}, 32'hFFFF);
          end else begin
            e = exp_tab[exp_rd];
            exp_rd++;
            chk("grant_id", {30'd0, grant_id}, {28'd0, e.id});
            chk("piso_data", {24'd0, piso_data}, {24'd0, e.word});
            chk("req_ready", {28'd0, req_ready}, 32'd1 << e.id);
            if (e.interval != 0) chk("load_period", cyc - last_load, {24'd0, e.interval});
            if (e.resume) chk("resume_delay", cyc - en_rise, 1);
            $display("[TB] load t=%0d id=%0d word=%02h", cyc, grant_id, piso_data);
            cur_word = e.word;
          end
          model_sr = piso_data;
          in_frame = 1'b1; nbits = 0; last_load = cyc;
        end else begin
          chk("req_ready_idle", {28'd0, req_ready}, 32'd0);
        end
      end

      if (tb_done && !mon_final) begin
        chk("all_grants_seen", exp_rd, exp_wr);
        chk("no_timeouts", tmo, 0);
        chk("frames_completed", frames_seen, exp_wr - ABORTED);
        mon_final = 1'b1;
      end
    end
  end

endmodule
